// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates N_CH requesters onto a single memory_unit port. A winning
//   channel's func/addresses/write data are latched, one execute pulse is
//   issued, the ready low/high handshake is waited out, and read data is
//   returned with a one-cycle per-channel done pulse. Supports fixed
//   priority or round-robin arbitration, a per-channel bus lock for
//   multi-op sequences, and a sticky timeout flag for a stuck memory.
//
//   Ports
//     clk, rst                 clock, synchronous active-high reset
//     req_execute/req_lock     per-channel request level / keep-grant hint
//     req_func/addr1/addr2     per-channel op fields, packed by channel
//     req_wdata                per-channel write data, packed by channel
//     req_done                 one-hot completion pulse
//     rd_data1/rd_data2        captured read data, held until next op
//     grant_valid/grant_id     current owner of the memory
//     err                      sticky timeout flag
//     mem_*                    memory_unit interface
//
//   state      | meaning
//   -----------+-------------------------------------------------
//   S_IDLE     | no op in flight; arbitrate when memory is ready
//   S_GRANT    | winner fields latched, grant_valid asserted
//   S_ISSUE    | mem_execute pulsed for one cycle
//   S_WAIT_LOW | waiting for memory to drop ready (op accepted)
//   S_WAIT_HIGH| waiting for memory to raise ready (op finished)
//   S_DONE     | req_done pulse, lock sampled
module mem_arbiter #(
  parameter int N_CH    = 5,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 64,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 255,
  localparam int IDW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req_execute,
  input  logic [N_CH-1:0]          req_lock,
  input  logic [2*N_CH-1:0]        req_func,
  input  logic [ADDR_W*N_CH-1:0]   req_addr1,
  input  logic [ADDR_W*N_CH-1:0]   req_addr2,
  input  logic [DATA_W*N_CH-1:0]   req_wdata,
  output logic [N_CH-1:0]          req_done,
  output logic [DATA_W-1:0]        rd_data1,
  output logic [DATA_W-1:0]        rd_data2,
  output logic                     grant_valid,
  output logic [IDW-1:0]           grant_id,
  output logic                     err,
  output logic [1:0]               mem_func,
  output logic                     mem_execute,
  output logic [ADDR_W-1:0]        mem_address1,
  output logic [ADDR_W-1:0]        mem_address2,
  output logic [DATA_W-1:0]        mem_write_data,
  input  logic                     mem_ready,
  input  logic [DATA_W-1:0]        mem_read_data1,
  input  logic [DATA_W-1:0]        mem_read_data2
);

  // Down-counter loaded on each wait-phase entry; terminal count 0 means
  // the phase has lasted TIMEOUT cycles.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TMO_LOAD_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TMO_LOAD_I);
  localparam bit TMO_EN = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GRANT     = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_LOW  = 3'd3,
    S_WAIT_HIGH = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [1:0]        func_arr  [N_CH];
  logic [ADDR_W-1:0] addr1_arr [N_CH];
  logic [ADDR_W-1:0] addr2_arr [N_CH];
  logic [DATA_W-1:0] wdata_arr [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign func_arr[i]  = req_func[2*i +: 2];
    assign addr1_arr[i] = req_addr1[ADDR_W*i +: ADDR_W];
    assign addr2_arr[i] = req_addr2[ADDR_W*i +: ADDR_W];
    assign wdata_arr[i] = req_wdata[DATA_W*i +: DATA_W];
  end

  logic [1:0]        op_func;
  logic [ADDR_W-1:0] op_addr1;
  logic [ADDR_W-1:0] op_addr2;
  logic [DATA_W-1:0] op_wdata;
  logic [IDW-1:0]    rr_ptr;
  logic              locked;
  logic [TW-1:0]     tmo_cnt;

  logic [IDW-1:0] fp_id;
  logic [IDW-1:0] rr_id;
  logic           rr_found;
  int             rr_idx;
  logic           lock_hit;
  logic [IDW-1:0] arb_id;
  logic [IDW-1:0] rr_next;
  logic           tmo_hit;
  logic           active;

  assign tmo_hit = TMO_EN && (tmo_cnt == '0);

  always_comb begin
    fp_id    = '0;
    rr_id    = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    lock_hit = 1'b0;
    arb_id   = '0;
    rr_next  = '0;

    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_execute[IDW'(i)]) fp_id = IDW'(i);
    end

    // Scan starting at rr_ptr, wrapping modulo N_CH.
    for (int k = 0; k < N_CH; k++) begin
      rr_idx = int'(rr_ptr) + k;
      if (rr_idx >= N_CH) rr_idx = rr_idx - N_CH;
      if (!rr_found && req_execute[IDW'(rr_idx)]) begin
        rr_found = 1'b1;
        rr_id    = IDW'(rr_idx);
      end
    end

    // A held lock whose owner still requests pre-empts arbitration; a lock
    // whose owner has gone quiet falls through to normal arbitration.
    lock_hit = locked && req_execute[grant_id];
    if (lock_hit)          arb_id = grant_id;
    else if (RR_MODE != 0) arb_id = rr_id;
    else                   arb_id = fp_id;

    if (arb_id == IDW'(N_CH - 1)) rr_next = '0;
    else                          rr_next = arb_id + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (mem_ready && (|req_execute)) state_nxt = S_GRANT;
      S_GRANT:     state_nxt = S_ISSUE;
      S_ISSUE:     state_nxt = S_WAIT_LOW;
      S_WAIT_LOW: begin
        if (!mem_ready)   state_nxt = S_WAIT_HIGH;
        else if (tmo_hit) state_nxt = S_DONE;
      end
      S_WAIT_HIGH: if (mem_ready || tmo_hit) state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      locked      <= 1'b0;
      rr_ptr      <= '0;
      tmo_cnt     <= '0;
      err         <= 1'b0;
      rd_data1    <= '0;
      rd_data2    <= '0;
      op_func     <= '0;
      op_addr1    <= '0;
      op_addr2    <= '0;
      op_wdata    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (locked && !req_execute[grant_id]) begin
            locked      <= 1'b0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
          end
          if (state_nxt == S_GRANT) begin
            locked      <= 1'b0;
            grant_valid <= 1'b1;
            grant_id    <= arb_id;
            op_func     <= func_arr[arb_id];
            op_addr1    <= addr1_arr[arb_id];
            op_addr2    <= addr2_arr[arb_id];
            op_wdata    <= wdata_arr[arb_id];
            rr_ptr      <= rr_next;
          end
        end
        S_ISSUE: tmo_cnt <= TMO_LOAD;
        S_WAIT_LOW: begin
          if (!mem_ready) begin
            tmo_cnt <= TMO_LOAD;
          end else begin
            if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
            if (tmo_hit) begin
              err      <= 1'b1;
              rd_data1 <= mem_read_data1;
              rd_data2 <= mem_read_data2;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (mem_ready || tmo_hit) begin
            rd_data1 <= mem_read_data1;
            rd_data2 <= mem_read_data2;
          end
          if (!mem_ready) begin
            if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
            if (tmo_hit) err <= 1'b1;
          end
        end
        S_DONE: begin
          locked <= req_lock[grant_id];
          if (!req_lock[grant_id]) begin
            grant_valid <= 1'b0;
            grant_id    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory-side fields come only from the latched op; zero while idle.
  assign active         = (state != S_IDLE);
  assign mem_execute    = (state == S_ISSUE);
  assign mem_func       = active ? op_func  : '0;
  assign mem_address1   = active ? op_addr1 : '0;
  assign mem_address2   = active ? op_addr2 : '0;
  assign mem_write_data = active ? op_wdata : '0;
  assign req_done       = (state == S_DONE) ? (N_CH'(1) << grant_id) : '0;

endmodule
